ex_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline, directly upstream of MEM. Registers the ID->EX bus,

---
 rtl/ex_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the 5-stage MIPS pipeline, directly upstream of MEM.
//
// Registers the ID->EX bus, computes the ALU result (which is also the
// load/store byte address), drives the data SRAM request and produces the
// EX->MEM bus combinationally from the registered instruction.
//
// Optional feature macro: EX_DIV_EN
//   defined     : iterative 32-step restoring divider with HI/LO registers and
//                 a stall request (34 stall cycles per divide).
//   not defined : no divider; div_op is ignored, stallreq_for_ex = 0,
//                 hi_o = lo_o = 0.
//
// Ports
//   clk             in   1    clock
//   rst             in   1    synchronous, active-high reset
//   stall           in   6    stall[2] = ID held, stall[3] = EX held (1 = stop)
//   id_to_ex_bus    in   151  {mem_op,div_op,alu_op,src_a,src_b,st_data,pc,
//                              ram_en,ram_wen,sel_rf_res,rf_we,rf_waddr}
//   ex_to_mem_bus   out  81   {mem_op,pc,ram_en,ram_wen,sel_rf_res,rf_we,
//                              rf_waddr,ex_result}
//   stallreq_for_ex out  1    divider busy
//   data_sram_en    out  1    data SRAM enable
//   data_sram_wen   out  4    byte write enables
//   data_sram_addr  out  32   byte address (= ex_result)
//   data_sram_wdata out  32   store data, replicated across byte lanes
//   hi_o / lo_o     out  32   HI / LO register contents
module ex_stage #(
  parameter int ID_TO_EX_WD  = 151,
  parameter int EX_TO_MEM_WD = 81
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic [31:0]             hi_o,
  output logic [31:0]             lo_o
);

  localparam int DATA_W = 32;

  logic [ID_TO_EX_WD-1:0] bus_p0;

  logic [4:0]               mem_op;
  logic [1:0]               div_op;
  logic [3:0]               alu_op;
  logic signed [DATA_W-1:0] src_a;
  logic signed [DATA_W-1:0] src_b;
  logic [DATA_W-1:0]        st_data;
  logic [DATA_W-1:0]        pc;
  logic                     ram_en;
  logic [3:0]               ram_wen;
  logic                     sel_rf_res;
  logic                     rf_we;
  logic [4:0]               rf_waddr;
  logic [DATA_W-1:0]        ex_result;
  logic [4:0]               shamt;

  // Two's-complement magnitude of v when it is a negative signed operand.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // ---- stage p0: ID->EX register ----
  // stall[2] set with stall[3] clear inserts a bubble; both set holds.
  always_ff @(posedge clk) begin
    if (rst)            bus_p0 <= '0;
    else if (!stall[2]) bus_p0 <= id_to_ex_bus;
    else if (!stall[3]) bus_p0 <= '0;
  end

  assign {mem_op, div_op, alu_op, src_a, src_b, st_data, pc,
          ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr} = bus_p0;

  assign shamt = src_a[4:0];

  always_comb begin
    ex_result = '0;
    case (alu_op)
      4'd0:    ex_result = src_a + src_b;
      4'd1:    ex_result = src_a - src_b;
      4'd2:    ex_result = src_a & src_b;
      4'd3:    ex_result = src_a | src_b;
      4'd4:    ex_result = src_a ^ src_b;
      4'd5:    ex_result = ~(src_a | src_b);
      4'd6:    ex_result = {31'b0, src_a < src_b};
      4'd7:    ex_result = {31'b0, $unsigned(src_a) < $unsigned(src_b)};
      4'd8:    ex_result = src_b << shamt;
      4'd9:    ex_result = $unsigned(src_b) >> shamt;
      4'd10:   ex_result = src_b >>> shamt;
      4'd11:   ex_result = {src_b[15:0], 16'b0};
      default: ex_result = '0;
    endcase
  end

  assign ex_to_mem_bus = {mem_op, pc, ram_en, ram_wen, sel_rf_res, rf_we,
                          rf_waddr, ex_result};

  // mem_op is one-hot: [0] lw, [1] sw, [2] sb, [3] sh.
  always_comb begin
    data_sram_wen   = 4'b0000;
    data_sram_wdata = st_data;
    if (mem_op[1]) begin
      data_sram_wen = 4'b1111;
    end else if (mem_op[2]) begin
      data_sram_wen   = 4'b0001 << ex_result[1:0];
      data_sram_wdata = {4{st_data[7:0]}};
    end else if (mem_op[3]) begin
      data_sram_wen   = ex_result[1] ? 4'b1100 : 4'b0011;
      data_sram_wdata = {2{st_data[15:0]}};
    end
  end

  assign data_sram_addr = ex_result;
  assign data_sram_en   = ram_en & ~stallreq_for_ex;

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

  div_state_t        state, state_nxt;
  logic [4:0]        cnt;
  logic              div_done;
  logic              div_start;
  logic              div_signed;
  logic              bus_load;
  logic [DATA_W-1:0] hi, lo;
  logic [DATA_W-1:0] quo_p1, rem_p1, dvsr_p1;
  logic              neg_q_p1, neg_r_p1;
  logic [DATA_W:0]   rem_sh;
  logic              sub_ok;

  // div and divu both set is treated as signed.
  assign div_signed = div_op[0];
  // div_done guards the held instruction from restarting once it finished.
  assign div_start  = (div_op != 2'b00) && !div_done;
  assign bus_load   = !stall[2] || !stall[3];

  always_comb begin
    state_nxt       = state;
    stallreq_for_ex = 1'b0;
    case (state)
      S_IDLE: if (div_start) begin
        stallreq_for_ex = 1'b1;
        state_nxt       = S_RUN;
      end
      S_RUN: begin
        stallreq_for_ex = 1'b1;
        if (cnt == 5'd31) state_nxt = S_DONE;
      end
      S_DONE: begin
        stallreq_for_ex = 1'b1;
        state_nxt       = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_sh = {rem_p1, quo_p1[DATA_W-1]};
  assign sub_ok = rem_sh >= {1'b0, dvsr_p1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_done <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_RUN) cnt <= cnt + 5'd1;
      else                cnt <= '0;
      if (bus_load)              div_done <= 1'b0;
      else if (state == S_DONE)  div_done <= 1'b1;
      if (state == S_DONE) begin
        // Zero divisor leaves rem = |dividend|, so HI recovers the dividend.
        lo <= (dvsr_p1 == '0) ? '1 : apply_sign(quo_p1, neg_q_p1);
        hi <= apply_sign(rem_p1, neg_r_p1);
      end
    end
  end

  // ---- stage p1: divider datapath ----
  always_ff @(posedge clk) begin
    if (state == S_IDLE && div_start) begin
      quo_p1   <= magnitude(src_a, div_signed);
      dvsr_p1  <= magnitude(src_b, div_signed);
      rem_p1   <= '0;
      neg_q_p1 <= div_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
      neg_r_p1 <= div_signed & src_a[DATA_W-1];
    end else if (state == S_RUN) begin
      quo_p1 <= {quo_p1[DATA_W-2:0], sub_ok};
      rem_p1 <= sub_ok ? (rem_sh[DATA_W-1:0] - dvsr_p1) : rem_sh[DATA_W-1:0];
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;
`else
  logic unused_div;
  assign unused_div      = ^div_op;
  assign stallreq_for_ex = 1'b0;
  assign hi_o            = '0;
  assign lo_o            = '0;
`endif

  logic unused_stall;
  assign unused_stall = ^{stall[5:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- scoreboard bench for ex_stage. Stimulus pushes expected
// values tagged with the cycle they must appear in; a monitor on the falling
// edge pops and compares them. Divider checks follow EX_DIV_EN.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall, stall_man;
  logic [150:0] id_bus;
  logic [80:0]  ex_to_mem_bus;
  logic         stallreq;
  logic         sram_en;
  logic [3:0]   sram_wen;
  logic [31:0]  sram_addr, sram_wdata, hi, lo;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .stallreq_for_ex (stallreq),
    .data_sram_en    (sram_en),
    .data_sram_wen   (sram_wen),
    .data_sram_addr  (sram_addr),
    .data_sram_wdata (sram_wdata),
    .hi_o            (hi),
    .lo_o            (lo)
  );

  always #5 clk = ~clk;

  // Bench acts as the pipeline controller: a divider stall holds IF..EX.
  assign stall = stall_man | (stallreq ? 6'b001111 : 6'b000000);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int F_BUS = 0, F_RES = 1, F_EN = 2, F_WEN = 3, F_ADDR = 4,
                 F_WDATA = 5, F_STALL = 6, F_HI = 7, F_LO = 8;

  typedef struct {
    int          cyc;
    int          fld;
    logic [80:0] exp;
  } chk_t;

  chk_t sb[$];
  int nvec  = 0;
  int nfail = 0;

  function automatic string fname(int f);
    case (f)
      F_BUS:   return "ex_to_mem_bus";
      F_RES:   return "ex_result";
      F_EN:    return "sram_en";
      F_WEN:   return "sram_wen";
      F_ADDR:  return "sram_addr";
      F_WDATA: return "sram_wdata";
      F_STALL: return "stallreq";
      F_HI:    return "hi";
      F_LO:    return "lo";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [80:0] actual(int f);
    case (f)
      F_BUS:   return ex_to_mem_bus;
      F_RES:   return 81'(ex_to_mem_bus[31:0]);
      F_EN:    return 81'(sram_en);
      F_WEN:   return 81'(sram_wen);
      F_ADDR:  return 81'(sram_addr);
      F_WDATA: return 81'(sram_wdata);
      F_STALL: return 81'(stallreq);
      F_HI:    return 81'(hi);
      F_LO:    return 81'(lo);
      default: return '1;
    endcase
  endfunction

  task automatic expect32(input int f, input int dly, input logic [31:0] v);
    chk_t c;
    c.cyc = cyc + dly;
    c.fld = f;
    c.exp = 81'(v);
    sb.push_back(c);
  endtask

  task automatic expect_bus(input int dly, input logic [80:0] v);
    chk_t c;
    c.cyc = cyc + dly;
    c.fld = F_BUS;
    c.exp = v;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [150:0] mk(input logic [4:0] mo, input logic [1:0] dop,
                                      input logic [3:0] aop, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] st,
                                      input logic [31:0] pc, input logic ren,
                                      input logic [3:0] rwen, input logic sel,
                                      input logic we, input logic [4:0] wa);
    return {mo, dop, aop, a, b, st, pc, ren, rwen, sel, we, wa};
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        chk_t c;
        logic [80:0] act;
        c   = sb.pop_front();
        act = actual(c.fld);
        nvec++;
        if (c.cyc != cyc) begin
          nfail++;
          $display("FAIL %s late: due cyc %0d, seen cyc %0d", fname(c.fld), c.cyc, cyc);
        end else if (act !== c.exp) begin
          nfail++;
          $display("FAIL %s @cyc %0d: got %h, want %h", fname(c.fld), cyc, act, c.exp);
        end
      end
    end
  end

  logic [3:0]  alu_op_t[14] = '{4'd1, 4'd6, 4'd10, 4'd0, 4'd2, 4'd3, 4'd4,
                                4'd5, 4'd7, 4'd6, 4'd8, 4'd9, 4'd11, 4'd13};
  logic [31:0] a_t[14]   = '{32'd5, 32'd5, 32'd4, 32'hFFFFFFFF, 32'hF0F0, 32'hF0F0,
                             32'hF0F0, 32'd0, 32'd5, 32'd5, 32'h24, 32'd4, 32'd0, 32'd5};
  logic [31:0] b_t[14]   = '{32'd7, 32'd7, 32'h80000000, 32'd1, 32'hFF00, 32'hFF00,
                             32'hFF00, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                             32'h80000000, 32'h1234, 32'd7};
  logic [31:0] r_t[14]   = '{32'hFFFFFFFE, 32'd1, 32'hF8000000, 32'd0, 32'hF000, 32'hFFF0,
                             32'h0FF0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h10, 32'h08000000,
                             32'h12340000, 32'd0};

  logic [4:0]  mo_m[6]   = '{5'b00100, 5'b01000, 5'b01000, 5'b00010, 5'b00100, 5'b00001};
  logic [31:0] a_m[6]    = '{32'h1000, 32'h2000, 32'h2000, 32'h3000, 32'h0, 32'h4000};
  logic [31:0] b_m[6]    = '{32'd3, 32'd2, 32'd0, 32'd0, 32'd1, 32'd4};
  logic [31:0] st_m[6]   = '{32'hAB, 32'h1234CDEF, 32'h1234CDEF, 32'hDEADBEEF, 32'h5A, 32'h0};
  logic [3:0]  wen_m[6]  = '{4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b0010, 4'b0000};
  logic [31:0] wd_m[6]   = '{32'hABABABAB, 32'hCDEFCDEF, 32'hCDEFCDEF, 32'hDEADBEEF,
                             32'h5A5A5A5A, 32'h0};

  // Divide: issue at cycle c, then a follow-up add; check stall window and HI/LO.
  task automatic run_div(input logic [1:0] dop, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic [31:0] nxt_a);
    id_bus = mk(5'b0, dop, 4'd0, a, b, 32'h0, 32'h40, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2);
`ifdef EX_DIV_EN
    expect32(F_STALL, 1, 32'd1);
    expect32(F_STALL, 17, 32'd1);
    expect32(F_STALL, 34, 32'd1);
    expect32(F_EN, 20, 32'd0);
    expect32(F_STALL, 35, 32'd0);
    expect32(F_RES, 35, a + b);
    expect32(F_LO, 35, exp_lo);
    expect32(F_HI, 35, exp_hi);
    expect32(F_STALL, 36, 32'd0);
    expect32(F_RES, 36, nxt_a + 32'd1);
`else
    expect32(F_STALL, 1, 32'd0);
    expect32(F_LO, 1, 32'd0);
    expect32(F_HI, 1, 32'd0);
    expect32(F_RES, 2, nxt_a + 32'd1);
    if (exp_lo == exp_hi) expect32(F_HI, 2, 32'd0);
`endif
    tick();
    id_bus = mk(5'b0, 2'b00, 4'd0, nxt_a, 32'd1, 32'h0, 32'h44, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3);
    repeat (36) tick();
  endtask

  initial begin
    rst       = 1'b1;
    stall_man = 6'b0;
    id_bus    = mk(5'b00010, 2'b00, 4'd0, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 4'hF,
                   1'b1, 1'b1, 5'h1F);
    repeat (2) tick();

    // Reset state
    expect_bus(0, 81'h0);
    expect32(F_EN, 0, 32'd0);
    expect32(F_WEN, 0, 32'd0);
    expect32(F_STALL, 0, 32'd0);
    expect32(F_HI, 0, 32'd0);
    expect32(F_LO, 0, 32'd0);
    rst = 1'b0;

    // Full bus pass-through on a sub
    id_bus = mk(5'b0, 2'b00, 4'd1, 32'd5, 32'd7, 32'h0, 32'h100, 1'b0, 4'h0, 1'b1, 1'b1, 5'd3);
    expect_bus(1, {5'b0, 32'h100, 1'b0, 4'h0, 1'b1, 1'b1, 5'd3, 32'hFFFFFFFE});
    tick();

    // ALU table
    for (int i = 0; i < 14; i++) begin
      id_bus = mk(5'b0, 2'b00, alu_op_t[i], a_t[i], b_t[i], 32'h0, 32'h200, 1'b0, 4'h0,
                  1'b0, 1'b1, 5'(i));
      expect32(F_RES, 1, r_t[i]);
      tick();
    end

    // Loads/stores
    for (int i = 0; i < 6; i++) begin
      id_bus = mk(mo_m[i], 2'b00, 4'd0, a_m[i], b_m[i], st_m[i], 32'h300, 1'b1, wen_m[i],
                  mo_m[i][0], mo_m[i][0], 5'd4);
      expect32(F_ADDR, 1, a_m[i] + b_m[i]);
      expect32(F_WEN, 1, 32'(wen_m[i]));
      expect32(F_EN, 1, 32'd1);
      if (!mo_m[i][0]) expect32(F_WDATA, 1, wd_m[i]);
      tick();
    end
    id_bus = mk(5'b00001, 2'b00, 4'd0, 32'h10, 32'h0, 32'h0, 32'h304, 1'b0, 4'h0,
                1'b1, 1'b1, 5'd4);
    expect32(F_EN, 1, 32'd0);
    tick();

    // Bubble: ID held, EX free
    id_bus = mk(5'b0, 2'b00, 4'd0, 32'd1, 32'd2, 32'h0, 32'h400, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5);
    expect32(F_RES, 1, 32'd3);
    tick();
    stall_man = 6'b000100;
    id_bus = mk(5'b0, 2'b00, 4'd0, 32'd10, 32'd10, 32'h0, 32'h404, 1'b1, 4'h0, 1'b0, 1'b1, 5'd6);
    expect_bus(1, 81'h0);
    tick();

    // Hold: ID and EX both held
    stall_man = 6'b0;
    id_bus = mk(5'b0, 2'b00, 4'd0, 32'd7, 32'd8, 32'h0, 32'h408, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7);
    expect32(F_RES, 1, 32'd15);
    tick();
    stall_man = 6'b001100;
    id_bus = mk(5'b0, 2'b00, 4'd0, 32'd10, 32'd10, 32'h0, 32'h40C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8);
    expect32(F_RES, 1, 32'd15);
    expect32(F_RES, 2, 32'd15);
    tick();
    tick();
    stall_man = 6'b0;
    expect32(F_RES, 1, 32'd20);
    tick();

    // Divides
    run_div(2'b01, -32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1);
    run_div(2'b10, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 32'd2);
    run_div(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'd3);

    // Reset ten cycles into a divide
    id_bus = mk(5'b0, 2'b01, 4'd0, 32'd7, 32'd1, 32'h0, 32'h48, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9);
`ifdef EX_DIV_EN
    expect32(F_STALL, 1, 32'd1);
    expect32(F_LO, 10, 32'h80000000);
    expect32(F_STALL, 10, 32'd1);
`else
    expect32(F_STALL, 1, 32'd0);
`endif
    tick();
    id_bus = mk(5'b0, 2'b00, 4'd0, 32'd9, 32'd9, 32'h0, 32'h4C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9);
    repeat (9) tick();
    rst = 1'b1;
    expect32(F_STALL, 1, 32'd0);
    expect32(F_LO, 1, 32'd0);
    expect32(F_HI, 1, 32'd0);
    expect_bus(1, 81'h0);
    tick();
    rst = 1'b0;
    id_bus = mk(5'b0, 2'b00, 4'd0, 32'd3, 32'd4, 32'h0, 32'h50, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10);
    expect32(F_RES, 1, 32'd7);
    expect32(F_STALL, 1, 32'd0);
    tick();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      chk_t c;
      c = sb.pop_front();
      nvec++;
      nfail++;
      $display("FAIL %s timeout: expectation for cyc %0d never checked", fname(c.fld), c.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
